// File: rtl/progress_tracker.sv
// Progress bar producer: converts loader start/advance/abort pulses into the
// current/max/enable triple for the overlay, with post-completion hold and stall hide.
module progress_tracker #(
    parameter logic [25:0] HOLD_CYCLES  = 26'd32_000_000,
    parameter logic [25:0] STALL_CYCLES = 26'd64_000_000,
    parameter logic [24:0] MIN_MAX      = 25'd128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [24:0] size,
    input  logic        advance,
    input  logic        abort,
    output logic [24:0] current,
    output logic [24:0] max,
    output logic        enable,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [25:0] timer_reg, timer_next;
    logic [24:0] count_reg, count_next;
    logic [24:0] size_reg, size_next;
    logic [24:0] current_reg, current_next;
    logic [24:0] max_reg, max_next;
    logic        enable_reg, enable_next;
    logic        done_reg, done_next;
    logic [24:0] count_inc;

    assign count_inc = count_reg + 25'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            timer_reg   <= 26'd0;
            count_reg   <= 25'd0;
            size_reg    <= 25'd0;
            current_reg <= 25'd0;
            max_reg     <= MIN_MAX;
            enable_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            count_reg   <= count_next;
            size_reg    <= size_next;
            current_reg <= current_next;
            max_reg     <= max_next;
            enable_reg  <= enable_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        count_next   = count_reg;
        size_next    = size_reg;
        current_next = current_reg;
        max_next     = max_reg;
        enable_next  = enable_reg;
        done_next    = 1'b0;

        if (start) begin
            // A small size is clamped so the overlay step max[24:7] is never zero.
            max_next   = (size < MIN_MAX) ? MIN_MAX : size;
            size_next  = size;
            count_next = 25'd0;
            timer_next = 26'd0;
            enable_next = 1'b1;
            if (size == 25'd0) begin
                state_next   = HOLD;
                current_next = MIN_MAX;
                done_next    = 1'b1;
            end else begin
                state_next   = ACTIVE;
                current_next = 25'd0;
            end
        end else begin
            case (state_reg)
                ACTIVE: begin
                    if (abort) begin
                        state_next  = HOLD;
                        timer_next  = 26'd0;
                        enable_next = 1'b1;
                    end else if (advance) begin
                        count_next  = count_inc;
                        timer_next  = 26'd0;
                        enable_next = 1'b1;
                        if (count_inc == size_reg) begin
                            state_next   = HOLD;
                            current_next = max_reg;
                            done_next    = 1'b1;
                        end else begin
                            current_next = (count_inc > max_reg) ? max_reg : count_inc;
                        end
                    end else if (timer_reg == STALL_CYCLES - 26'd1) begin
                        // Timer parks here so the bar stays hidden until the next advance.
                        enable_next = 1'b0;
                    end else begin
                        timer_next = timer_reg + 26'd1;
                    end
                end
                HOLD: begin
                    if (abort || timer_reg == HOLD_CYCLES - 26'd1) begin
                        state_next  = IDLE;
                        enable_next = 1'b0;
                    end else begin
                        timer_next  = timer_reg + 26'd1;
                        enable_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign current = current_reg;
    assign max     = max_reg;
    assign enable  = enable_reg;
    assign done    = done_reg;
    assign busy    = (state_reg == ACTIVE);

endmodule

// File: tb/tb_progress_tracker.sv
// Directed bench for progress_tracker with short hold/stall timers.
module tb_progress_tracker;

    localparam logic [25:0] HOLD  = 26'd20;
    localparam logic [25:0] STALL = 26'd10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [24:0] size = 25'd0;
    logic        advance = 1'b0;
    logic        abort = 1'b0;
    logic [24:0] current;
    logic [24:0] max;
    logic        enable;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    progress_tracker #(
        .HOLD_CYCLES (HOLD),
        .STALL_CYCLES(STALL),
        .MIN_MAX     (25'd128)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .size   (size),
        .advance(advance),
        .abort  (abort),
        .current(current),
        .max    (max),
        .enable (enable),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [24:0] s);
        start = 1'b1;
        size  = s;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (current !== 25'd0 || max !== 25'd128 || enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got cur=%0d max=%0d en=%b busy=%b done=%b want cur=0 max=128 en=0 busy=0 done=0",
                     tag, current, max, enable, busy, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        check_reset_values("reset_state");
        reset_n = 1'b1;
        step();
        check_reset_values("after_release");
        $display("test_reset done");
    endtask

    task automatic test_full_transfer();
        int bad = 0;
        do_start(25'd1000);
        checks++;
        if (current !== 25'd0 || max !== 25'd1000 || enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_start: got cur=%0d max=%0d en=%b busy=%b want 0 1000 1 1", current, max, enable, busy);
        end
        for (int i = 1; i <= 1000; i++) begin
            advance = 1'b1;
            step();
            if (current !== 25'(i) || done !== (i == 1000)) bad++;
        end
        advance = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_track: got %0d bad steps want 0", bad);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || current !== 25'd1000) begin
            errors++;
            $display("FAIL full_done: got done=%b busy=%b cur=%0d want 1 0 1000", done, busy, current);
        end
        step();
        checks++;
        if (done !== 1'b0 || enable !== 1'b1) begin
            errors++;
            $display("FAIL full_done_pulse: got done=%b en=%b want 0 1", done, enable);
        end
        for (int i = 0; i < 18; i++) step();
        checks++;
        if (enable !== 1'b1) begin
            errors++;
            $display("FAIL hold_visible: got en=%b want 1", enable);
        end
        step();
        checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || current !== 25'd1000 || max !== 25'd1000) begin
            errors++;
            $display("FAIL hold_expire: got en=%b busy=%b cur=%0d max=%0d want 0 0 1000 1000", enable, busy, current, max);
        end
        $display("test_full_transfer done");
    endtask

    task automatic test_small_size();
        do_start(25'd50);
        checks++;
        if (max !== 25'd128) begin
            errors++;
            $display("FAIL small_max: got %0d want 128", max);
        end
        advance = 1'b1;
        for (int i = 0; i < 49; i++) step();
        checks++;
        if (current !== 25'd49 || done !== 1'b0) begin
            errors++;
            $display("FAIL small_49: got cur=%0d done=%b want 49 0", current, done);
        end
        step();
        advance = 1'b0;
        checks++;
        if (current !== 25'd128 || done !== 1'b1) begin
            errors++;
            $display("FAIL small_last: got cur=%0d done=%b want 128 1", current, done);
        end
        advance = 1'b1;
        step();
        advance = 1'b0;
        checks++;
        if (current !== 25'd128 || done !== 1'b0) begin
            errors++;
            $display("FAIL small_extra_adv: got cur=%0d done=%b want 128 0", current, done);
        end
        $display("test_small_size done");
    endtask

    task automatic test_zero_size();
        do_start(25'd0);
        checks++;
        if (max !== 25'd128 || current !== 25'd128 || done !== 1'b1 || busy !== 1'b0 || enable !== 1'b1) begin
            errors++;
            $display("FAIL zero_size: got max=%0d cur=%0d done=%b busy=%b en=%b want 128 128 1 0 1",
                     max, current, done, busy, enable);
        end
        $display("test_zero_size done");
    endtask

    task automatic test_start_priority();
        start = 1'b1;
        advance = 1'b1;
        size = 25'd400;
        step();
        start = 1'b0;
        checks++;
        if (current !== 25'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_with_adv: got cur=%0d busy=%b want 0 1", current, busy);
        end
        for (int i = 0; i < 300; i++) step();
        advance = 1'b0;
        checks++;
        if (current !== 25'd300) begin
            errors++;
            $display("FAIL restart_pre: got cur=%0d want 300", current);
        end
        do_start(25'd2000);
        checks++;
        if (current !== 25'd0 || max !== 25'd2000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got cur=%0d max=%0d busy=%b want 0 2000 1", current, max, busy);
        end
        $display("test_start_priority done");
    endtask

    task automatic test_stall();
        do_start(25'd2000);
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (enable !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: got en=%b want 1", enable);
        end
        step();
        checks++;
        if (enable !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hide: got en=%b busy=%b want 0 1", enable, busy);
        end
        for (int i = 0; i < 5; i++) step();
        advance = 1'b1;
        step();
        advance = 1'b0;
        checks++;
        if (enable !== 1'b1 || current !== 25'd1) begin
            errors++;
            $display("FAIL stall_resume: got en=%b cur=%0d want 1 1", enable, current);
        end
        $display("test_stall done");
    endtask

    task automatic test_abort();
        do_start(25'd1000);
        advance = 1'b1;
        for (int i = 0; i < 500; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        advance = 1'b0;
        checks++;
        if (current !== 25'd500 || done !== 1'b0 || busy !== 1'b0 || enable !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: got cur=%0d done=%b busy=%b en=%b want 500 0 0 1", current, done, busy, enable);
        end
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || current !== 25'd500) begin
            errors++;
            $display("FAIL abort_idle: got en=%b busy=%b cur=%0d want 0 0 500", enable, busy, current);
        end
        advance = 1'b1;
        step();
        advance = 1'b0;
        checks++;
        if (current !== 25'd500 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got cur=%0d busy=%b want 500 0", current, busy);
        end
        $display("test_abort done");
    endtask

    task automatic test_async_reset();
        do_start(25'd1000);
        advance = 1'b1;
        for (int i = 0; i < 5; i++) step();
        advance = 1'b0;
        checks++;
        if (current !== 25'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got cur=%0d busy=%b want 5 1", current, busy);
        end
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        step();
        reset_n = 1'b1;
        step();
        check_reset_values("async_release");
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_small_size();
        test_zero_size();
        test_start_priority();
        test_stall();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
